tetris_key_decoder: RTL and testbench
=====================================

Name: tetris_key_decoder

Overview:
- Converts the PS/2 Set-2 scan-code byte stream into one-cycle game action pulses for movement_module.
- Handles E0/F0 prefixes, tracks per-action held state and generates auto-repeat for held moves.
- Sits between the PS/2 byte receiver (deframes PS2_CLK/PS2_DAT into bytes) and movement_module.

Parameters:
- DAS_CYCLES, 8_500_000, hold time in clocks before auto-repeat starts (170 ms at 50 MHz).
- ARR_CYCLES, 2_500_000, left/right auto-repeat period in clocks (50 ms).
- SDR_CYCLES, 1_500_000, soft_drop repeat period in clocks (30 ms); soft_drop has no DAS delay.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- code_valid  in  1  one-cycle strobe: code_byte is a complete received byte.
- code_byte  in  8  scan-code byte.
- code_err  in  1  one-cycle strobe: receiver framing/parity error on the current byte.
- left, right, soft_drop, hard_drop, rotate_cw, rotate_ccw, hold_piece  out  1 each  registered one-cycle action pulses.
- held  out  7  registered held mask {left,right,soft_drop,hard_drop,rotate_cw,rotate_ccw,hold_piece}, MSB = left.

Behaviour:
- Reset (asynchronous, reset_n=0): all pulses = 0, held = 0, prefix FSM = IDLE, repeat counters = 0.
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: on E0 go to EXT; on F0 go to BRK; any other byte is a make code.
  - EXT: on F0 go to EXT_BRK; any other byte is an extended make code, then go to IDLE.
  - BRK / EXT_BRK: the byte is a break code (plain or extended), then go to IDLE.
- code_err: the FSM returns to IDLE and the byte is discarded. code_err has priority over a coincident code_valid.
- Key map:
  - E0 6B = left; E0 74 = right; E0 72 = soft_drop; 29 (space) = hard_drop.
  - E0 75 (up) and 22 (X) = rotate_cw; 1A (Z) = rotate_ccw; 21 (C) = hold_piece.
  - Unmapped codes are ignored; the FSM still returns to IDLE.
- rotate_cw has two sources, each with its own internal held bit. held[2] is the OR of both bits.
- Make of an action that is not held: set its held bit and pulse the action once.
  - Latency: the pulse is high in the cycle after the code_valid of the final byte.
- Make of an action that is already held (keyboard typematic): no pulse, no state change.
- Break: clear the held bit; no pulse. A break of a key that is not held is ignored.
- Left/right:
  - The last pressed of the two wins; only the winner pulses and repeats.
  - Releasing the winner while the other is still held makes the other the active direction. It does not pulse immediately; it restarts DAS from 0.
  - Repeat for the active direction: a counter starts at the initial pulse. At DAS_CYCLES it pulses, then it pulses every ARR_CYCLES while held.
- soft_drop repeat: after the initial pulse, it pulses every SDR_CYCLES while held.
- hard_drop, rotate_cw, rotate_ccw, hold_piece never repeat.
- Simultaneous events: multiple action pulses may be high in the same cycle, e.g. a repeat of left and a new make of rotate_ccw.
- Counter widths: $clog2 of the largest parameter plus 1 bit. A counter saturates at 0 when its key is not held.

Optional Feature:
- Macro: TKD_AUTOREPEAT_EN.
- Defined: DAS/ARR/SDR repeat as described above.
- Undefined: no repeat logic or counters are built. Pulses occur on press only; the left/right last-pressed rule still applies, and a re-activated direction does not pulse.

Decomposition:
- Shared package tetris_pkg:
  - action index enum (LEFT … HOLD), matching the held bit order;
  - scan-code localparams (SC_E0, SC_F0, SC_LEFT, …);
  - prefix FSM state enum.
- Sub-module key_repeat_timer (parameters: initial delay, period):
  - inputs: start, hold; output: repeat strobe.
  - Two instances: one for the active left/right direction, one for soft_drop (initial delay = period = SDR_CYCLES).

Test Plan:
- Bench parameters: DAS=20, ARR=5, SDR=3.
- 1A -> rotate_ccw high for exactly 1 cycle, the cycle after that strobe; F0 1A -> no pulse and held[1]=0.
- E0 6B held for 40 cycles -> left pulses at t+1, t+21, t+26, t+31, t+36; then E0 F0 6B -> no further pulses and held[6]=0.
- Press left, then right, then release right after 10 cycles -> right pulses once; no left pulse at release; left pulses 20 cycles after the release, then every 5.
- Typematic: 29 sent three times -> exactly one hard_drop pulse; F0 29 followed by 29 -> second pulse.
- E0 followed by a code_err strobe, then 72 -> the FSM is in IDLE, 72 is unmapped, so no soft_drop pulse; reset_n low mid-DAS -> all outputs 0 immediately, asynchronously.
- Build without TKD_AUTOREPEAT_EN, hold E0 74 for 100 cycles -> exactly one right pulse.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the Tetris key decoder: action indices, PS/2 Set-2 scan codes,
// prefix FSM states and the scan-code to key-source decode.
package tetris_pkg;

  // Action index equals the bit position in the held mask and the pulse vector.
  typedef enum logic [2:0] {
    ACT_LEFT  = 3'd6,
    ACT_RIGHT = 3'd5,
    ACT_SOFT  = 3'd4,
    ACT_HARD  = 3'd3,
    ACT_RCW   = 3'd2,
    ACT_RCCW  = 3'd1,
    ACT_HOLD  = 3'd0
  } action_e;

  localparam int N_ACT = 7;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } prefix_state_e;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_C     = 8'h21;

  // Physical key sources; rotate_cw has two (Up and X), each tracked separately.
  localparam int SRC_LEFT   = 7;
  localparam int SRC_RIGHT  = 6;
  localparam int SRC_SOFT   = 5;
  localparam int SRC_HARD   = 4;
  localparam int SRC_RCW_UP = 3;
  localparam int SRC_RCW_X  = 2;
  localparam int SRC_RCCW   = 1;
  localparam int SRC_HOLD   = 0;
  localparam int N_SRC      = 8;

  function automatic logic [N_SRC-1:0] decode_key(input logic ext, input logic [7:0] code);
    logic [N_SRC-1:0] src;
    src = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  src[SRC_LEFT]   = 1'b1;
        SC_RIGHT: src[SRC_RIGHT]  = 1'b1;
        SC_DOWN:  src[SRC_SOFT]   = 1'b1;
        SC_UP:    src[SRC_RCW_UP] = 1'b1;
        default:  src = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: src[SRC_HARD]  = 1'b1;
        SC_X:     src[SRC_RCW_X] = 1'b1;
        SC_Z:     src[SRC_RCCW]  = 1'b1;
        SC_C:     src[SRC_HOLD]  = 1'b1;
        default:  src = '0;
      endcase
    end
    return src;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer: after start, strobes once INIT_DLY cycles later and then
// every PERIOD cycles while hold stays high; the count rests at 0 when not held.
module key_repeat_timer #(
  parameter int INIT_DLY = 8_500_000,
  parameter int PERIOD   = 2_500_000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic rpt
);

  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_DLY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] target;

  assign target = phase_q ? PERIOD_C : INIT_C;

  // The count reads k in the k-th cycle after start, so a strobe here lands on the
  // registered pulse output exactly INIT_DLY (then PERIOD) cycles after the first pulse.
  always_comb begin
    rpt     = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (start) begin
      cnt_d   = ONE_C;
      phase_d = 1'b0;
    end else if (!hold) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == target) begin
      rpt     = 1'b1;
      cnt_d   = ONE_C;
      phase_d = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tetris_key_decoder.sv
// PS/2 Set-2 scan codes to one-cycle Tetris action pulses with held tracking.
// Auto-repeat (DAS/ARR for left/right, SDR for soft_drop) is built only with TKD_AUTOREPEAT_EN.
module tetris_key_decoder
  import tetris_pkg::*;
#(
  parameter int DAS_CYCLES = 8_500_000,
  parameter int ARR_CYCLES = 2_500_000,
  parameter int SDR_CYCLES = 1_500_000
)
(
  input  logic          CLOCK_50,
  input  logic          reset_n,
  // code_valid / code_err are single-cycle strobes with no backpressure: every byte
  // offered is consumed in that cycle, and code_err wins over a coincident code_valid.
  input  logic          code_valid,
  input  logic [7:0]    code_byte,
  input  logic          code_err,
  output logic          left,
  output logic          right,
  output logic          soft_drop,
  output logic          hard_drop,
  output logic          rotate_cw,
  output logic          rotate_ccw,
  output logic          hold_piece,
  output logic [6:0]    held,
  output prefix_state_e dbg_state
);

  localparam logic [N_SRC-1:0] RCW_MASK = (N_SRC'(1) << SRC_RCW_UP) | (N_SRC'(1) << SRC_RCW_X);

  prefix_state_e    state_q, state_d;
  logic             is_make, is_break, is_ext;
  logic [N_SRC-1:0] src_mask, make_src, brk_src, new_src;
  logic [N_SRC-1:0] src_held_q, src_held_d;
  logic             dir_q, dir_d;
  logic             swap_to_r, swap_to_l;
  logic [N_ACT-1:0] pulse_q, pulse_d;
  logic [N_ACT-1:0] held_q, held_d;
  logic             lr_rep, sd_rep;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= PS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (code_err) begin
      state_d = PS_IDLE;
    end else if (code_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (code_byte == SC_E0)      state_d = PS_EXT;
          else if (code_byte == SC_F0) state_d = PS_BRK;
          else                         state_d = PS_IDLE;
        end
        PS_EXT:  state_d = (code_byte == SC_F0) ? PS_EXT_BRK : PS_IDLE;
        default: state_d = PS_IDLE;
      endcase
    end
  end

  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    if (code_valid && !code_err) begin
      case (state_q)
        PS_IDLE:    is_make = (code_byte != SC_E0) && (code_byte != SC_F0);
        PS_EXT: begin
          is_make = (code_byte != SC_F0);
          is_ext  = 1'b1;
        end
        PS_BRK:     is_break = 1'b1;
        PS_EXT_BRK: begin
          is_break = 1'b1;
          is_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign src_mask   = decode_key(is_ext, code_byte);
  assign make_src   = is_make  ? src_mask : '0;
  assign brk_src    = is_break ? src_mask : '0;
  assign new_src    = make_src & ~src_held_q;
  assign src_held_d = (src_held_q | make_src) & ~brk_src;

  // Releasing the active direction hands control to the other one if it is still down.
  assign swap_to_r = brk_src[SRC_LEFT]  & ~dir_q & src_held_q[SRC_RIGHT];
  assign swap_to_l = brk_src[SRC_RIGHT] &  dir_q & src_held_q[SRC_LEFT];

  always_comb begin
    dir_d = dir_q;
    if (new_src[SRC_LEFT])       dir_d = 1'b0;
    else if (new_src[SRC_RIGHT]) dir_d = 1'b1;
    else if (swap_to_r)          dir_d = 1'b1;
    else if (swap_to_l)          dir_d = 1'b0;
  end

  always_comb begin
    held_d = {src_held_d[SRC_LEFT], src_held_d[SRC_RIGHT], src_held_d[SRC_SOFT],
              src_held_d[SRC_HARD], |(src_held_d & RCW_MASK), src_held_d[SRC_RCCW],
              src_held_d[SRC_HOLD]};
  end

  always_comb begin
    pulse_d            = '0;
    pulse_d[ACT_LEFT]  = new_src[SRC_LEFT]  | (lr_rep & ~dir_q);
    pulse_d[ACT_RIGHT] = new_src[SRC_RIGHT] | (lr_rep &  dir_q);
    pulse_d[ACT_SOFT]  = new_src[SRC_SOFT]  | sd_rep;
    pulse_d[ACT_HARD]  = new_src[SRC_HARD];
    pulse_d[ACT_RCW]   = (|(new_src & RCW_MASK)) & ~(|(src_held_q & RCW_MASK));
    pulse_d[ACT_RCCW]  = new_src[SRC_RCCW];
    pulse_d[ACT_HOLD]  = new_src[SRC_HOLD];
  end

`ifdef TKD_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(max3(DAS_CYCLES, ARR_CYCLES, SDR_CYCLES)) + 1;

  logic lr_start, lr_hold;

  // A reactivated direction restarts DAS without an immediate pulse.
  assign lr_start = new_src[SRC_LEFT] | new_src[SRC_RIGHT] | swap_to_r | swap_to_l;
  assign lr_hold  = dir_d ? src_held_d[SRC_RIGHT] : src_held_d[SRC_LEFT];

  key_repeat_timer #(
    .INIT_DLY (DAS_CYCLES),
    .PERIOD   (ARR_CYCLES),
    .CNT_W    (CNT_W)
  ) u_lr_timer (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .start (lr_start),
    .hold  (lr_hold),
    .rpt   (lr_rep)
  );

  key_repeat_timer #(
    .INIT_DLY (SDR_CYCLES),
    .PERIOD   (SDR_CYCLES),
    .CNT_W    (CNT_W)
  ) u_sd_timer (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .start (new_src[SRC_SOFT]),
    .hold  (src_held_d[SRC_SOFT]),
    .rpt   (sd_rep)
  );
`else
  assign lr_rep = 1'b0;
  assign sd_rep = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      src_held_q <= '0;
      dir_q      <= 1'b0;
      pulse_q    <= '0;
      held_q     <= '0;
    end else begin
      src_held_q <= src_held_d;
      dir_q      <= dir_d;
      pulse_q    <= pulse_d;
      held_q     <= held_d;
    end
  end

  assign left       = pulse_q[ACT_LEFT];
  assign right      = pulse_q[ACT_RIGHT];
  assign soft_drop  = pulse_q[ACT_SOFT];
  assign hard_drop  = pulse_q[ACT_HARD];
  assign rotate_cw  = pulse_q[ACT_RCW];
  assign rotate_ccw = pulse_q[ACT_RCCW];
  assign hold_piece = pulse_q[ACT_HOLD];
  assign held       = held_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Directed bench for tetris_key_decoder: a monitor logs every action pulse with its
// cycle number into obs_q, and each scenario compares that log against exp_q.
module tb_tetris_key_decoder;

  localparam int DAS = 20;
  localparam int ARR = 5;
  localparam int SDR = 3;

  localparam int A_LEFT = 6, A_RIGHT = 5, A_SOFT = 4, A_HARD = 3, A_RCW = 2, A_RCCW = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       code_valid, code_err;
  logic [7:0] code_byte;
  logic       left, right, soft_drop, hard_drop, rotate_cw, rotate_ccw, hold_piece;
  logic [6:0] held;
  logic [1:0] dbg_state;
  logic [6:0] pulses;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0, t1, t2;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  tetris_key_decoder #(
    .DAS_CYCLES (DAS),
    .ARR_CYCLES (ARR),
    .SDR_CYCLES (SDR)
  ) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code_byte  (code_byte),
    .code_err   (code_err),
    .left       (left),
    .right      (right),
    .soft_drop  (soft_drop),
    .hard_drop  (hard_drop),
    .rotate_cw  (rotate_cw),
    .rotate_ccw (rotate_ccw),
    .hold_piece (hold_piece),
    .held       (held),
    .dbg_state  (dbg_state)
  );

  assign pulses = {left, right, soft_drop, hard_drop, rotate_cw, rotate_ccw, hold_piece};

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse seen at a falling edge becomes {action, cycle}
  always @(negedge clk) begin
    if (reset_n) begin
      for (int a = 6; a >= 0; a--) begin
        if (pulses[a]) obs_q.push_back({a[2:0], cyc[28:0]});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all start and end just after a falling edge
  task automatic send_byte(input logic [7:0] b);
    code_byte  = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic send_err(input logic with_valid, input logic [7:0] b);
    code_byte  = b;
    code_valid = with_valid;
    code_err   = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    code_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard helpers
  task automatic expect_pulse(input int a, input int c);
    exp_q.push_back({a[2:0], c[28:0]});
  endtask

  task automatic expect_repeats(input int a, input int first, input int period, input int last);
`ifdef TKD_AUTOREPEAT_EN
    for (int c = first; c <= last; c += period) expect_pulse(a, c);
`else
    if (a < 0 || first < 0 || period < 0 || last < 0) $display("bad repeat window");
`endif
  endtask

  task automatic compare_sb(input string tag);
    int n;
    obs_q.sort();
    exp_q.sort();
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: observed timeout, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    code_valid = 1'b0;
    code_err   = 1'b0;
    code_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pulses", 32'(pulses), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    idle(2);

    // Z: single rotate_ccw pulse, then F0 1A clears held[1] silently
    send_byte(8'h1A);
    expect_pulse(A_RCCW, cyc);
    idle(3);
    check("rccw_held", 32'(held), 32'(7'b0000010));
    send_byte(8'hF0);
    check("state_brk", 32'(dbg_state), 32'(ST_BRK));
    send_byte(8'h1A);
    idle(3);
    check("rccw_released", 32'(held), 32'd0);
    compare_sb("rccw");

    // Left held: DAS then ARR, with a coincident rotate_ccw make at t0+25
    send_byte(8'hE0);
    check("state_ext", 32'(dbg_state), 32'(ST_EXT));
    send_byte(8'h6B);
    t0 = cyc;
    expect_pulse(A_LEFT, t0);
    expect_repeats(A_LEFT, t0 + DAS, ARR, t0 + 35);
    wait_until(t0 + 24);
    send_byte(8'h1A);
    expect_pulse(A_RCCW, t0 + 25);
    wait_until(t0 + 30);
    check("left_held", 32'(held), 32'(7'b1000010));
    wait_until(t0 + 36);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    send_byte(8'hF0); send_byte(8'h1A);
    idle(25);
    check("left_released", 32'(held), 32'd0);
    compare_sb("left_das");

    // Left, then right wins; releasing right re-arms left without a pulse
    send_byte(8'hE0); send_byte(8'h6B);
    t1 = cyc;
    expect_pulse(A_LEFT, t1);
    send_byte(8'hE0); send_byte(8'h74);
    t2 = cyc;
    expect_pulse(A_RIGHT, t2);
    wait_until(t2 + 10);
    check("lr_held", 32'(held), 32'(7'b1100000));
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    t0 = cyc;
    expect_repeats(A_LEFT, t0 + DAS, ARR, t0 + 30);
    wait_until(t0 + 31);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    idle(10);
    check("lr_released", 32'(held), 32'd0);
    compare_sb("lr_swap");

    // Typematic repeats of a held key are swallowed
    send_byte(8'h29);
    expect_pulse(A_HARD, cyc);
    send_byte(8'h29); send_byte(8'h29);
    idle(2);
    check("hard_held", 32'(held), 32'(7'b0001000));
    send_byte(8'hF0); send_byte(8'h29);
    idle(2);
    check("hard_released", 32'(held), 32'd0);
    send_byte(8'h29);
    expect_pulse(A_HARD, cyc);
    idle(2);
    send_byte(8'hF0); send_byte(8'h29);
    idle(2);
    compare_sb("typematic");

    // Soft drop repeats every SDR cycles with no initial delay
    send_byte(8'hE0); send_byte(8'h72);
    t0 = cyc;
    expect_pulse(A_SOFT, t0);
    expect_repeats(A_SOFT, t0 + SDR, SDR, t0 + 9);
    wait_until(t0 + 7);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    idle(6);
    check("soft_released", 32'(held), 32'd0);
    compare_sb("soft_drop");

    // X then Up: rotate_cw pulses once, stays held until both sources are released
    send_byte(8'h22);
    expect_pulse(A_RCW, cyc);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'h22);
    idle(2);
    check("rcw_up_held", 32'(held), 32'(7'b0000100));
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(2);
    check("rcw_released", 32'(held), 32'd0);
    compare_sb("rotate_cw");

    // code_err drops the prefix; it also wins over a coincident code_valid
    send_byte(8'hE0);
    send_err(1'b0, 8'h00);
    check("err_idle", 32'(dbg_state), 32'(ST_IDLE));
    send_byte(8'h72);
    idle(3);
    check("err_held", 32'(held), 32'd0);
    send_byte(8'hE0);
    send_err(1'b1, 8'h6B);
    check("err_prio_idle", 32'(dbg_state), 32'(ST_IDLE));
    send_byte(8'h6B);
    idle(3);
    compare_sb("err_discard");

    // Asynchronous reset while right is held and its pulse is high
    send_byte(8'hE0); send_byte(8'h74);
    expect_pulse(A_RIGHT, cyc);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pulses", 32'(pulses), 32'd0);
    check("arst_held", 32'(held), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    idle(30);
    check("arst_after", 32'(held), 32'd0);
    compare_sb("async_rst");

    // Right held for 100 cycles: one pulse without repeat, DAS/ARR train with it
    send_byte(8'hE0); send_byte(8'h74);
    t0 = cyc;
    expect_pulse(A_RIGHT, t0);
    expect_repeats(A_RIGHT, t0 + DAS, ARR, t0 + 100);
    wait_until(t0 + 99);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    idle(10);
    check("right_released", 32'(held), 32'd0);
    compare_sb("right_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
